// File: rtl/pp_shift_pipe.sv
// pp_shift_pipe: two-stage valid/ready partial-product shifter.
// Shifts CHANNELS lanes of SIZE bits in lockstep, either logical left with
// zero fill or arithmetic right with sign fill, by a per-transaction amount
// clamped to MAX_SHIFT.
// Optional feature macro: PP_SHIFT_OVF_EN adds per-lane signed-overflow
// flags for left shifts; without it ovf_o is tied low.
module pp_shift_pipe #(
  parameter int SIZE      = 18,
  parameter int CHANNELS  = 4,
  parameter int MAX_SHIFT = 7,
  localparam int SHW      = $clog2(MAX_SHIFT + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [CHANNELS*SIZE-1:0] in_data_i,
  input  logic [SHW-1:0]           shamt_i,
  input  logic                     mode_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [CHANNELS*SIZE-1:0] out_data_o,
  output logic [CHANNELS-1:0]      ovf_o
);

  logic                     s1Valid_q;
  logic [CHANNELS*SIZE-1:0] s1Data_q;
  logic [SHW-1:0]           s1Shamt_q;
  logic                     s1Mode_q;

  logic                     s2Valid_q;
  logic [CHANNELS*SIZE-1:0] s2Data_q;
  logic [CHANNELS*SIZE-1:0] s2Data_d;

  logic                     s1Ready;
  logic                     s2Ready;
  logic [SHW-1:0]           effShamt;
  logic [SIZE-1:0]          lane;

  // The ready chain is purely combinational so a stalled consumer freezes
  // every stage in the same cycle and a draining consumer frees them all.
  assign s2Ready    = !s2Valid_q || out_ready_i;
  assign s1Ready    = !s1Valid_q || s2Ready;
  assign in_ready_o = s1Ready;

  assign out_valid_o = s2Valid_q;
  assign out_data_o  = s2Data_q;

  // Clamp the stored shift amount so an oversize request saturates at MAX_SHIFT.
  always_comb begin
    effShamt = s1Shamt_q;
    if (int'(s1Shamt_q) > MAX_SHIFT) begin
      effShamt = SHW'(MAX_SHIFT);
    end
  end

  // Per-lane width-preserving shift of the S1 payload feeding S2.
  always_comb begin
    s2Data_d = '0;
    lane     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      lane = s1Data_q[k*SIZE +: SIZE];
      if (s1Mode_q) begin
        s2Data_d[k*SIZE +: SIZE] = $signed(lane) >>> effShamt;
      end else begin
        s2Data_d[k*SIZE +: SIZE] = lane << effShamt;
      end
    end
  end

  // S1 captures the request on an input handshake and empties when it drains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s1Shamt_q <= '0;
      s1Mode_q  <= 1'b0;
    end else if (s1Ready) begin
      s1Valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1Data_q  <= in_data_i;
        s1Shamt_q <= shamt_i;
        s1Mode_q  <= mode_i;
      end
    end
  end

  // S2 holds the shifted result; data keeps its last value when the stage empties.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2Valid_q <= 1'b0;
      s2Data_q  <= '0;
    end else if (s2Ready) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Data_q <= s2Data_d;
      end
    end
  end

`ifdef PP_SHIFT_OVF_EN
  logic [CHANNELS-1:0] s2Ovf_q;
  logic [CHANNELS-1:0] s2Ovf_d;
  logic [SIZE-1:0]     ovfLane;
  logic [SIZE-1:0]     ovfShifted;
  logic [SIZE-1:0]     ovfBack;

  // A left shift overflows when shifting back arithmetically fails to
  // recover the original lane, i.e. the discarded bits and new MSB disagree.
  always_comb begin
    s2Ovf_d    = '0;
    ovfLane    = '0;
    ovfShifted = '0;
    ovfBack    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      ovfLane    = s1Data_q[k*SIZE +: SIZE];
      ovfShifted = ovfLane << effShamt;
      ovfBack    = $signed(ovfShifted) >>> effShamt;
      s2Ovf_d[k] = !s1Mode_q && (ovfBack != ovfLane);
    end
  end

  // Overflow flags travel with the S2 data under the same enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2Ovf_q <= '0;
    end else if (s2Ready && s1Valid_q) begin
      s2Ovf_q <= s2Ovf_d;
    end
  end

  assign ovf_o = s2Ovf_q;
`else
  assign ovf_o = '0;
`endif

endmodule

// File: doc/pp_shift_pipe.md
Name: pp_shift_pipe

Overview:
- Parametrised, pipelined partial-product shifter for the signed multiplier datapath; the multi-channel successor to the fixed radix-8 shifter.
- Shifts CHANNELS partial products by a per-transaction amount, left with zero fill or arithmetic right with sign fill.
- Two-stage valid/ready pipeline with full backpressure; sits between the partial-product generator and the adder tree.

Parameters:
- SIZE, 18, width of each partial product in bits (>= MAX_SHIFT+2).
- CHANNELS, 4, number of partial-product lanes shifted in lockstep.
- MAX_SHIFT, 7, largest legal shift amount; SHW = $clog2(MAX_SHIFT+1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  input transaction valid.
- in_ready_o  out  1  pipeline can accept the input.
- in_data_i  in  CHANNELS*SIZE  packed lanes; lane k at [k*SIZE +: SIZE].
- shamt_i  in  SHW  shift amount for this transaction.
- mode_i  in  1  0 = logical left (zero fill), 1 = arithmetic right (sign fill).
- out_valid_o  out  1  output transaction valid.
- out_ready_i  in  1  consumer accepts the output.
- out_data_o  out  CHANNELS*SIZE  shifted lanes, same packing.
- ovf_o  out  CHANNELS  per-lane overflow flag (only with PP_SHIFT_OVF_EN; otherwise tied 0).

Behaviour:
- Reset (asynchronous, rst_ni low): s1_valid=0, s2_valid=0, out_valid_o=0, out_data_o=0, ovf_o=0, in_ready_o=1 after reset. Reset mid-operation discards all in-flight transactions with no partial output.
- Stage S1 registers in_data_i, shamt_i and mode_i on an input handshake (in_valid_i & in_ready_o).
- Stage S2 registers the shifted result from S1 and drives the outputs directly from its registers.
- Latency: 2 cycles from input handshake to out_valid_o when out_ready_i=1. Throughput: 1 transaction per cycle.
- Ready chain: s2_ready = !s2_valid | out_ready_i; s1_ready = !s1_valid | s2_ready; in_ready_o = s1_ready. The path is combinational from out_ready_i.
- Full: both stages valid and out_ready_i=0. in_ready_o=0; all registers hold; out_data_o stays stable while out_valid_o=1 and not accepted.
- Simultaneous accept and input: an output handshake and an input handshake in the same cycle both complete; no bubble is inserted.
- Empty: out_valid_o=0; out_data_o keeps its last value.
- Left shift (mode 0): lane = lane << shamt with zero fill; upper bits are discarded.
- Right shift (mode 1): lane = $signed(lane) >>> shamt; MSB is replicated.
- shamt=0 in either mode: passthrough.
- shamt > MAX_SHIFT: clamped to MAX_SHIFT.
- Arithmetic is width-preserving (SIZE in, SIZE out). Shift and clamp are computed combinationally between S1 and S2.

Optional Feature:
- Macro: PP_SHIFT_OVF_EN.
- Defined, mode 0: ovf_o[k]=1 when the bits shifted out of lane k plus the resulting MSB are not all equal, i.e. the signed value changed. Registered in S2 alongside the data.
- Defined, mode 1: ovf_o[k]=0 always.
- Undefined: no overflow logic is instantiated and ovf_o is tied to 0.

Test Plan:
- Reset and passthrough:
  - After release: in_ready_o=1, out_valid_o=0.
  - Send lane0=18'h00005, shamt=3, mode=0 with out_ready_i=1 -> out_valid_o high exactly 2 cycles later, lane0=18'h00028.
- Right shift:
  - lane1=18'h3FFF0 (-16), shamt=3, mode=1 -> lane1=18'h3FFFE (-2).
  - lane2=18'h00010, shamt=3, mode=1 -> 18'h00002.
- Backpressure:
  - Hold out_ready_i=0 and offer 3 back-to-back transactions -> first two accepted, in_ready_o=0 on the third, out_data_o stable.
  - Release out_ready_i -> all 3 emerge in order with no loss or duplication.
- Streaming: out_ready_i=1 and in_valid_i=1 for 16 cycles with incrementing data -> 16 outputs on consecutive cycles, in order.
- Clamp and reset:
  - shamt=7 with lane3=18'h00001 -> 18'h00080.
  - Assert rst_ni low with both stages full -> out_valid_o=0 immediately; out_data_o=0.
- Overflow (PP_SHIFT_OVF_EN):
  - lane0=18'h08000, shamt=3, mode=0 -> ovf_o[0]=1.
  - lane1=18'h3FFFF, shamt=3, mode=0 -> ovf_o[1]=0.
  - Without the macro, ovf_o=0 for both cases.
